// File: rtl/vit_encoder_stack_ctrl_pkg.sv
// Shared types for the ViT encoder-stack sequencer.
// Contents: stage enumeration, controller state enumeration, the pre-norm
// and post-norm stage orders, and helpers that look up a stage by position
// and turn a stage into its one-hot start/done bit.
package vit_encoder_stack_ctrl_pkg;

    typedef enum logic [2:0] {
        STG_LN1  = 3'd0,
        STG_ATT  = 3'd1,
        STG_RES1 = 3'd2,
        STG_LN2  = 3'd3,
        STG_MLP  = 3'd4,
        STG_RES2 = 3'd5
    } enc_stage_e;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_ISSUE      = 3'd1,
        S_WAIT       = 3'd2,
        S_NEXT_LAYER = 3'd3,
        S_DONE       = 3'd4,
        S_ERR        = 3'd5
    } ctrl_state_e;

    localparam int NUM_STAGES = 6;

    typedef enc_stage_e stage_order_t [NUM_STAGES];

    localparam stage_order_t PRE_NORM_ORDER  = '{STG_LN1, STG_ATT, STG_RES1, STG_LN2, STG_MLP, STG_RES2};
    localparam stage_order_t POST_NORM_ORDER = '{STG_ATT, STG_RES1, STG_LN1, STG_MLP, STG_RES2, STG_LN2};

    // Stage executed at a given position of the per-layer sequence.
    function automatic enc_stage_e stage_at(input logic post_norm, input logic [2:0] pos);
        enc_stage_e s;
        case (pos)
            3'd0:    s = post_norm ? POST_NORM_ORDER[0] : PRE_NORM_ORDER[0];
            3'd1:    s = post_norm ? POST_NORM_ORDER[1] : PRE_NORM_ORDER[1];
            3'd2:    s = post_norm ? POST_NORM_ORDER[2] : PRE_NORM_ORDER[2];
            3'd3:    s = post_norm ? POST_NORM_ORDER[3] : PRE_NORM_ORDER[3];
            3'd4:    s = post_norm ? POST_NORM_ORDER[4] : PRE_NORM_ORDER[4];
            3'd5:    s = post_norm ? POST_NORM_ORDER[5] : PRE_NORM_ORDER[5];
            default: s = STG_LN1;
        endcase
        return s;
    endfunction

    // One-hot lane of a stage on the stage_start / stage_done buses.
    function automatic logic [5:0] stage_onehot(input enc_stage_e s);
        logic [5:0] oh;
        case (s)
            STG_LN1:  oh = 6'b000001;
            STG_ATT:  oh = 6'b000010;
            STG_RES1: oh = 6'b000100;
            STG_LN2:  oh = 6'b001000;
            STG_MLP:  oh = 6'b010000;
            STG_RES2: oh = 6'b100000;
            default:  oh = 6'b000000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/vit_encoder_stack_ctrl_if.sv
// Sequencer <-> stage-engine / activation-memory interface.
// stage_start: one-hot start pulse (LN1,ATT,RES1,LN2,MLP,RES2 on bits 0..5)
// stage_done : per-stage done pulses from the engines
// layer_idx  : current layer (weight bank select)
// tok_idx    : token of the current MLP issue
// buf_sel    : activation buffer read by the engines; they write !buf_sel
interface vit_encoder_stack_ctrl_if #(
    parameter int SEQ_LEN    = 16,
    parameter int MAX_LAYERS = 12
);
    localparam int LAYER_W = (MAX_LAYERS > 1) ? $clog2(MAX_LAYERS) : 1;
    localparam int TOK_W   = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;

    logic [5:0]         stage_start;
    logic [5:0]         stage_done;
    logic [LAYER_W-1:0] layer_idx;
    logic [TOK_W-1:0]   tok_idx;
    logic               buf_sel;

    modport master (
        output stage_start,
        output layer_idx,
        output tok_idx,
        output buf_sel,
        input  stage_done
    );

    modport slave (
        input  stage_start,
        input  layer_idx,
        input  tok_idx,
        input  buf_sel,
        output stage_done
    );
endinterface

// File: rtl/vit_encoder_stack_ctrl_stage_watchdog.sv
// Per-stage watchdog.
// Ports: clk, rst (sync, active high); clr restarts the count; en counts one
// waiting cycle; expired is high in the waiting cycle that is the
// TIMEOUT_CYCLES-th since the last clear. TIMEOUT_CYCLES = 0 never expires.
module vit_encoder_stack_ctrl_stage_watchdog #(
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    // The count equals the number of waiting cycles already elapsed, so the
    // limit is one less than the timeout.
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

    logic [CNT_W-1:0] cnt_r;
    logic             at_limit_s;

    // Expiry decode, suppressed entirely when the watchdog is disabled.
    always_comb begin
        at_limit_s = (cnt_r == LIMIT);
        if (TIMEOUT_CYCLES == 0) begin
            expired = 1'b0;
        end else begin
            expired = en && at_limit_s;
        end
    end

    // Saturating wait-cycle counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (clr) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (en && !at_limit_s) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end
endmodule

// File: rtl/vit_encoder_stack_ctrl.sv
// Layer/stage sequencer for a multi-layer ViT encoder stack sharing one set
// of stage engines.
// Ports: clk, rst (sync, active high); start/abort from the top controller;
// cfg_num_layers (clamped to MAX_LAYERS) and cfg_post_norm latched at start;
// eng (master modport) carries stage_start/stage_done/layer_idx/tok_idx/buf_sel;
// busy (not idle), done (completion pulse), err_timeout (sticky watchdog error).
module vit_encoder_stack_ctrl
    import vit_encoder_stack_ctrl_pkg::*;
#(
    parameter int SEQ_LEN        = 16,
    parameter int MAX_LAYERS     = 12,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic                            abort,
    input  logic [$clog2(MAX_LAYERS+1)-1:0] cfg_num_layers,
    input  logic                            cfg_post_norm,
    vit_encoder_stack_ctrl_if.master        eng,
    output logic                            busy,
    output logic                            done,
    output logic                            err_timeout
);
    localparam int NL_W    = $clog2(MAX_LAYERS + 1);
    localparam int LAYER_W = (MAX_LAYERS > 1) ? $clog2(MAX_LAYERS) : 1;
    localparam int TOK_W   = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
    localparam logic [TOK_W-1:0] TOK_LAST = TOK_W'(SEQ_LEN - 1);

    ctrl_state_e        state_r, state_s;
    logic [2:0]         pos_r, pos_s;
    logic [LAYER_W-1:0] layer_r, layer_s;
    logic [TOK_W-1:0]   tok_r, tok_s;
    logic               buf_r, buf_s;
    logic               err_r, err_s;
    logic               post_r, post_s;
    logic [NL_W-1:0]    nl_r, nl_s;

    enc_stage_e         cur_stage_s;
    logic [NL_W-1:0]    cfg_layers_s;
    logic               done_hit_s;
    logic               last_layer_s;
    logic               wd_expired_s;

    vit_encoder_stack_ctrl_stage_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clr    (state_r == S_ISSUE),
        .en     (state_r == S_WAIT),
        .expired(wd_expired_s)
    );

    // Current stage, clamped layer count, and the only done lane that counts.
    always_comb begin
        cur_stage_s  = stage_at(post_r, pos_r);
        done_hit_s   = ((eng.stage_done & stage_onehot(cur_stage_s)) != 6'b000000);
        last_layer_s = (NL_W'(layer_r) == (nl_r - NL_W'(1)));
        if (cfg_num_layers > NL_W'(MAX_LAYERS)) begin
            cfg_layers_s = NL_W'(MAX_LAYERS);
        end else begin
            cfg_layers_s = cfg_num_layers;
        end
    end

    // Next-state and datapath updates; abort overrides every non-idle state.
    always_comb begin
        state_s = state_r;
        pos_s   = pos_r;
        layer_s = layer_r;
        tok_s   = tok_r;
        buf_s   = buf_r;
        err_s   = err_r;
        post_s  = post_r;
        nl_s    = nl_r;
        if (abort && (state_r != S_IDLE)) begin
            state_s = S_IDLE;
            pos_s   = 3'd0;
            layer_s = {LAYER_W{1'b0}};
            tok_s   = {TOK_W{1'b0}};
        end else if (abort) begin
            state_s = S_IDLE;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        post_s  = cfg_post_norm;
                        nl_s    = cfg_layers_s;
                        pos_s   = 3'd0;
                        layer_s = {LAYER_W{1'b0}};
                        tok_s   = {TOK_W{1'b0}};
                        buf_s   = 1'b0;
                        err_s   = 1'b0;
                        if (cfg_layers_s == {NL_W{1'b0}}) begin
                            state_s = S_DONE;
                        end else begin
                            state_s = S_ISSUE;
                        end
                    end else begin
                        state_s = S_IDLE;
                    end
                end
                S_ISSUE: begin
                    state_s = S_WAIT;
                end
                S_WAIT: begin
                    // A done in the expiry cycle still advances the sequence.
                    if (done_hit_s) begin
                        if ((cur_stage_s == STG_MLP) && (tok_r != TOK_LAST)) begin
                            tok_s   = tok_r + TOK_W'(1);
                            state_s = S_ISSUE;
                        end else begin
                            tok_s = {TOK_W{1'b0}};
                            if (pos_r == 3'd5) begin
                                state_s = S_NEXT_LAYER;
                            end else begin
                                pos_s   = pos_r + 3'd1;
                                state_s = S_ISSUE;
                            end
                        end
                    end else if (wd_expired_s) begin
                        err_s   = 1'b1;
                        state_s = S_ERR;
                    end else begin
                        state_s = S_WAIT;
                    end
                end
                S_NEXT_LAYER: begin
                    buf_s = ~buf_r;
                    if (last_layer_s) begin
                        state_s = S_DONE;
                    end else begin
                        layer_s = layer_r + LAYER_W'(1);
                        pos_s   = 3'd0;
                        state_s = S_ISSUE;
                    end
                end
                S_DONE: begin
                    state_s = S_IDLE;
                end
                S_ERR: begin
                    state_s = S_ERR;
                end
                default: begin
                    state_s = S_IDLE;
                end
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
            pos_r   <= 3'd0;
            layer_r <= {LAYER_W{1'b0}};
            tok_r   <= {TOK_W{1'b0}};
            buf_r   <= 1'b0;
            err_r   <= 1'b0;
            post_r  <= 1'b0;
            nl_r    <= {NL_W{1'b0}};
        end else begin
            state_r <= state_s;
            pos_r   <= pos_s;
            layer_r <= layer_s;
            tok_r   <= tok_s;
            buf_r   <= buf_s;
            err_r   <= err_s;
            post_r  <= post_s;
            nl_r    <= nl_s;
        end
    end

    // Outputs decoded from the state register; abort masks start and done in
    // the abort cycle itself.
    always_comb begin
        eng.stage_start = 6'b000000;
        done            = 1'b0;
        if ((state_r == S_ISSUE) && !abort) begin
            eng.stage_start = stage_onehot(cur_stage_s);
        end else begin
            eng.stage_start = 6'b000000;
        end
        if ((state_r == S_DONE) && !abort) begin
            done = 1'b1;
        end else begin
            done = 1'b0;
        end
        busy          = (state_r != S_IDLE);
        err_timeout   = err_r;
        eng.layer_idx = layer_r;
        eng.tok_idx   = tok_r;
        eng.buf_sel   = buf_r;
    end
endmodule
